mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer_if.sv | 21 ++
 rtl/mult_sequencer.sv | 106 ++++++++++
 tb/tb_mult_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_sequencer_if.sv
// rtl/mult_sequencer_if.sv - request/result bundle between the EX stage and the multiply sequencer
interface mult_sequencer_if;
  logic        start;
  logic        flush;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        stall;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  modport master (
    output start, flush, srca, srcb,
    input  stall, done, result_lo, result_hi
  );

  modport slave (
    input  start, flush, srca, srcb,
    output stall, done, result_lo, result_hi
  );
endinterface

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - shift-and-add 32x32 unsigned multiplier sequencer; MULT_EARLY_TERM_EN enables early termination
module mult_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  mult_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] mcand;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [63:0] res;
  logic [31:0] mplier;
  logic [5:0]  cnt;
  logic        last_iter;
  logic        accept;
  logic        iterate;
  logic        stall_c;
  logic        done_c;

  assign acc_next = acc + (mplier[0] ? mcand : 64'd0);

`ifdef MULT_EARLY_TERM_EN
  // Finish as soon as no set multiplier bits remain after this iteration's shift.
  assign last_iter = (cnt == 6'd31) || (mplier[31:1] == 31'd0);
`else
  assign last_iter = (cnt == 6'd31);
`endif

  assign accept  = (state == IDLE) && bus.start && !bus.flush;
  assign iterate = (state == RUN) && !bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          state_next = RUN;
          stall_c    = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          stall_c = 1'b1;
          if (last_iter) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= 64'd0;
      mplier <= 32'd0;
      acc    <= 64'd0;
      cnt    <= 6'd0;
      res    <= 64'd0;
    end else if (accept) begin
      mcand  <= {32'd0, bus.srca};
      mplier <= bus.srcb;
      acc    <= 64'd0;
      cnt    <= 6'd0;
    end else if (iterate) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      cnt    <= cnt + 6'd1;
      // Capture includes the final iteration's partial product.
      if (last_iter) begin
        res <= acc_next;
      end
    end
  end

  assign bus.stall     = stall_c & rst_n;
  assign bus.done      = done_c & rst_n;
  assign bus.result_lo = res[31:0];
  assign bus.result_hi = res[63:32];

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - directed and randomized checks of mult_sequencer against a product/latency model
module tb_mult_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mult_sequencer_if ifc ();

  mult_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [31:0] b);
    int h;
    h = -1;
`ifdef MULT_EARLY_TERM_EN
    for (int i = 0; i < 32; i++) begin
      if (b[i]) h = i;
    end
    return (h < 0) ? 2 : h + 2;
`else
    return 33 + h - h;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit flush_done);
    int          lat;
    logic [63:0] p;
    lat = exp_lat(b);
    p   = {32'd0, a} * {32'd0, b};
    cycle();
    ifc.start = 1'b1;
    ifc.flush = 1'b0;
    ifc.srca  = a;
    ifc.srcb  = b;
    settle();
    check("c0_stall", 64'(ifc.stall), 64'd1);
    check("c0_done", 64'(ifc.done), 64'd0);
    for (int c = 1; c <= lat; c++) begin
      cycle();
      if (hold) begin
        ifc.srca = $urandom;
        ifc.srcb = $urandom;
      end else begin
        ifc.start = 1'b0;
      end
      if (c == lat && flush_done) ifc.flush = 1'b1;
      settle();
      if (c < lat) begin
        check("run_stall", 64'(ifc.stall), 64'd1);
        check("run_done", 64'(ifc.done), 64'd0);
      end else begin
        check("done_pulse", 64'(ifc.done), 64'd1);
        check("done_stall", 64'(ifc.stall), 64'd0);
        check("product", {ifc.result_hi, ifc.result_lo}, p);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          fc;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    ifc.start = 1'b1;
    ifc.flush = 1'b0;
    ifc.srca  = 32'd3;
    ifc.srcb  = 32'd5;

    cycle();
    cycle();
    settle();
    check("rst_stall", 64'(ifc.stall), 64'd0);
    check("rst_done", 64'(ifc.done), 64'd0);
    check("rst_result", {ifc.result_hi, ifc.result_lo}, 64'd0);
    cycle();
    rst_n     = 1'b1;
    ifc.start = 1'b0;
    settle();
    check("idle_stall", 64'(ifc.stall), 64'd0);

    // Basic and extreme operands
    run_op(32'd3, 32'd5, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(32'd9, 32'd0, 1'b0, 1'b0);
    run_op(32'd7, 32'd2, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    run_op(32'd3, 32'd5, 1'b0, 1'b0);

    // Flush during RUN: no done pulse, result held at 15
    lat = exp_lat(32'd9);
    fc  = (lat > 11) ? 10 : 1;
    cycle();
    ifc.start = 1'b1;
    ifc.srca  = 32'd7;
    ifc.srcb  = 32'd9;
    settle();
    for (int c = 1; c <= fc; c++) begin
      cycle();
      ifc.start = 1'b0;
      if (c == fc) ifc.flush = 1'b1;
      settle();
    end
    check("flush_cycle_stall", 64'(ifc.stall), 64'd0);
    for (int c = 0; c < 40; c++) begin
      cycle();
      ifc.flush = 1'b0;
      settle();
      check("post_flush_done", 64'(ifc.done), 64'd0);
      check("post_flush_stall", 64'(ifc.stall), 64'd0);
    end
    check("post_flush_result", 64'(ifc.result_lo), 64'd15);

    // start and flush together in IDLE
    cycle();
    ifc.start = 1'b1;
    ifc.flush = 1'b1;
    settle();
    check("start_flush_stall", 64'(ifc.stall), 64'd0);
    cycle();
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    settle();
    check("start_flush_idle", 64'(ifc.stall), 64'd0);
    check("start_flush_done", 64'(ifc.done), 64'd0);

    // Reset in RUN cycle 20
    cycle();
    ifc.start = 1'b1;
    ifc.srca  = $urandom;
    ifc.srcb  = 32'hFFFF_FFFF;
    settle();
    for (int c = 1; c <= 20; c++) begin
      cycle();
      ifc.start = 1'b0;
      if (c == 20) rst_n = 1'b0;
      settle();
    end
    check("mid_rst_stall", 64'(ifc.stall), 64'd0);
    check("mid_rst_done", 64'(ifc.done), 64'd0);
    cycle();
    rst_n = 1'b1;
    settle();
    check("after_rst_result", {ifc.result_hi, ifc.result_lo}, 64'd0);
    check("after_rst_stall", 64'(ifc.stall), 64'd0);
    check("after_rst_done", 64'(ifc.done), 64'd0);
    run_op(32'd2, 32'd8, 1'b0, 1'b0);

    // start held through RUN/DONE, then back-to-back start from IDLE
    run_op($urandom, $urandom, 1'b1, 1'b0);
    run_op($urandom, $urandom, 1'b0, 1'b1);
    cycle();
    ifc.flush = 1'b0;
    settle();
    check("after_flush_done_idle", 64'(ifc.done), 64'd0);

    // Randomized operands with varied multiplier widths
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(31, 0);
      run_op(a, b, 1'(i % 3 == 0), 1'(i % 4 == 1));
    end
    cycle();
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
